// File: rtl/rd_req_svc_pkg.sv
// Shared types and frame-format constants for the read-request servicer.
// Header layout: bit 7 marker, bit 6 timeout, bit 5 overflow, bits 3:0 group id.
package rd_req_svc_pkg;

  localparam int DEF_TOTAL_UART       = 8;
  localparam int DEF_TOTAL_GPIO_CTRLS = 8;
  localparam int DEF_MAX_LEN          = 16;
  localparam int DEF_TIMEOUT          = 255;

  localparam int HDR_MARK = 7;
  localparam int HDR_TMO  = 6;
  localparam int HDR_OVF  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_HDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_ACK
  } state_e;

  function automatic int grp_count(input int n_uart, input int n_gpio);
    return ((n_uart + 3) >> 2) + ((n_gpio + 3) >> 2);
  endfunction

  function automatic logic [7:0] make_hdr(input logic tmo, input logic ovf, input logic [3:0] id);
    logic [7:0] h;
    h           = 8'h00;
    h[HDR_MARK] = 1'b1;
    h[HDR_TMO]  = tmo;
    h[HDR_OVF]  = ovf;
    h[3:0]      = id;
    return h;
  endfunction

endpackage

// File: rtl/rd_payload_buf.sv
// Payload store: synchronous write port, registered read port (data one cycle after rd_en_i).
// No flow control; read data holds while rd_en_i is low.
module rd_payload_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= 8'h00;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rd_req_svc.sv
// Drains one peripheral group into a local buffer, then streams header/length/payload to the host.
// grp_rd_en 1 cycle after rd_req; HDR 1 cycle after the last beat; stream stalls on tx_ready=0.
module rd_req_svc
  import rd_req_svc_pkg::*;
#(
  parameter int TOTAL_UART       = DEF_TOTAL_UART,
  parameter int TOTAL_GPIO_CTRLS = DEF_TOTAL_GPIO_CTRLS,
  parameter int TOTAL_GRP        = grp_count(TOTAL_UART, TOTAL_GPIO_CTRLS),
  parameter int MAX_LEN          = DEF_MAX_LEN,
  parameter int TIMEOUT          = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_req,
  input  logic [TOTAL_GRP-1:0] rd_slave_id,
  output logic                 rd_req_ack,
  output logic [TOTAL_GRP-1:0] grp_sel,
  output logic                 grp_rd_en,
  input  logic                 grp_rd_valid,
  input  logic [7:0]           grp_rd_data,
  input  logic                 grp_rd_last,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_last
);

  localparam int AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int IDW = (TOTAL_GRP < 4) ? TOTAL_GRP : 4;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT);

  state_e                 state_q;
  logic [TOTAL_GRP-1:0]   grp_sel_q;
  logic                   grp_rd_en_q;
  logic [7:0]             cnt_q;
  logic [TW-1:0]          tmr_q;
  logic [7:0]             idx_q;
  logic [7:0]             tx_byte_q;
  logic                   tx_valid_q;
  logic                   tx_last_q;
  logic                   ack_q;

  logic [3:0]    id_nib;
  logic [7:0]    cnt_inc;
  logic          hit_max;
  logic          buf_wr_en;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic [7:0]    buf_rd_data;

  assign id_nib  = 4'(grp_sel_q[IDW-1:0]);
  assign cnt_inc = cnt_q + 8'd1;
  assign hit_max = (cnt_inc == MAX_LEN_B);

  // Prefetch the next payload byte on every accepted byte so the stream has no bubbles.
  assign buf_wr_en   = (state_q == ST_READ) && grp_rd_valid;
  assign buf_rd_en   = tx_ready && (((state_q == ST_LEN) && (cnt_q != 8'd0)) ||
                                    ((state_q == ST_PAYLOAD) && !tx_last_q));
  assign buf_rd_addr = (state_q == ST_LEN) ? '0 : AW'(idx_q + 8'd1);

  rd_payload_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (cnt_q[AW-1:0]),
    .wr_data_i (grp_rd_data),
    .rd_en_i   (buf_rd_en),
    .rd_addr_i (buf_rd_addr),
    .rd_data_o (buf_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grp_sel_q   <= '0;
      grp_rd_en_q <= 1'b0;
      cnt_q       <= 8'd0;
      tmr_q       <= '0;
      idx_q       <= 8'd0;
      tx_byte_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rd_req) begin
            grp_sel_q   <= rd_slave_id;
            cnt_q       <= 8'd0;
            tmr_q       <= TMO_LOAD;
            grp_rd_en_q <= 1'b1;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          if (grp_rd_valid) begin
            cnt_q <= cnt_inc;
            tmr_q <= TMO_LOAD;
            if (grp_rd_last || hit_max) begin
              grp_rd_en_q <= 1'b0;
              tx_valid_q  <= 1'b1;
              tx_last_q   <= 1'b0;
              tx_byte_q   <= make_hdr(1'b0, !grp_rd_last, id_nib);
              state_q     <= ST_HDR;
            end
          end else if (tmr_q <= TW'(1)) begin
            tmr_q       <= '0;
            grp_rd_en_q <= 1'b0;
            tx_valid_q  <= 1'b1;
            tx_last_q   <= 1'b0;
            tx_byte_q   <= make_hdr(1'b1, 1'b0, id_nib);
            state_q     <= ST_HDR;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        ST_HDR: begin
          if (tx_ready) begin
            tx_byte_q <= cnt_q;
            tx_last_q <= (cnt_q == 8'd0);
            state_q   <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (tx_ready) begin
            if (cnt_q == 8'd0) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              tx_byte_q  <= 8'd0;
              ack_q      <= 1'b1;
              state_q    <= ST_ACK;
            end else begin
              idx_q     <= 8'd0;
              tx_last_q <= (cnt_q == 8'd1);
              state_q   <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (tx_ready) begin
            if (tx_last_q) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              tx_byte_q  <= 8'd0;
              ack_q      <= 1'b1;
              state_q    <= ST_ACK;
            end else begin
              idx_q     <= idx_q + 8'd1;
              tx_last_q <= ((idx_q + 8'd2) == cnt_q);
            end
          end
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_req_ack = ack_q;
  assign grp_sel    = grp_sel_q;
  assign grp_rd_en  = grp_rd_en_q;
  assign tx_valid   = tx_valid_q;
  assign tx_last    = tx_last_q;
  assign tx_data    = (state_q == ST_PAYLOAD) ? buf_rd_data : tx_byte_q;

endmodule

// File: tb/tb_rd_req_svc.sv
// Directed bench for rd_req_svc: frame-level model plus per-cycle stream/ack/enable checks.
module tb_rd_req_svc;

  localparam int MAXL = 4;
  localparam int TMO  = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_req;
  logic [3:0] rd_slave_id;
  logic       rd_req_ack;
  logic [3:0] grp_sel;
  logic       grp_rd_en;
  logic       grp_rd_valid;
  logic [7:0] grp_rd_data;
  logic       grp_rd_last;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  always #5 clk = ~clk;

  rd_req_svc #(
    .TOTAL_UART       (8),
    .TOTAL_GPIO_CTRLS (8),
    .MAX_LEN          (MAXL),
    .TIMEOUT          (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_req       (rd_req),
    .rd_slave_id  (rd_slave_id),
    .rd_req_ack   (rd_req_ack),
    .grp_sel      (grp_sel),
    .grp_rd_en    (grp_rd_en),
    .grp_rd_valid (grp_rd_valid),
    .grp_rd_data  (grp_rd_data),
    .grp_rd_last  (grp_rd_last),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_last      (tx_last)
  );

  int checks   = 0;
  int failures = 0;

  logic       bv[$];
  logic [7:0] bd[$];
  logic       bl[$];
  logic [8:0] mfr[$];
  int         m_en;
  logic [8:0] exp_q[$];
  int         en_cnt;
  logic [3:0] cur_id;
  logic       tgl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add_beat(input logic v, input logic [7:0] d, input logic l);
    bv.push_back(v);
    bd.push_back(d);
    bl.push_back(l);
  endtask

  task automatic clear_beats();
    bv.delete();
    bd.delete();
    bl.delete();
  endtask

  // Frame-level model: walk the beat list one read cycle at a time and build the expected stream.
  task automatic model_frame(input logic [3:0] id);
    logic [7:0] pay[$];
    int   c;
    int   idle;
    logic tmo;
    logic ovf;
    logic v;
    c = 0; idle = 0; tmo = 1'b0; ovf = 1'b0;
    mfr.delete();
    while (1) begin
      v = (c < bv.size()) ? bv[c] : 1'b0;
      if (v) begin
        pay.push_back(bd[c]);
        idle = 0;
        if (bl[c]) break;
        if (pay.size() == MAXL) begin ovf = 1'b1; break; end
      end else begin
        idle++;
        if (idle == TMO) begin tmo = 1'b1; break; end
      end
      c++;
    end
    m_en = c + 1;
    mfr.push_back({1'b0, 1'b1, tmo, ovf, 1'b0, id});
    mfr.push_back({pay.size() == 0, 8'(pay.size())});
    foreach (pay[i]) mfr.push_back({i == pay.size() - 1, pay[i]});
  endtask

  task automatic run_frame(input logic [3:0] id);
    logic got;
    model_frame(id);
    foreach (mfr[i]) exp_q.push_back(mfr[i]);
    cur_id = id;
    en_cnt = 0;
    rd_req = 1'b1;
    rd_slave_id = id;
    @(posedge clk); #1;
    chk("en_latency", grp_rd_en, 1);
    for (int i = 0; i < bv.size(); i++) begin
      grp_rd_valid = bv[i];
      grp_rd_data  = bd[i];
      grp_rd_last  = bl[i];
      @(posedge clk); #1;
    end
    grp_rd_valid = 1'b0;
    grp_rd_last  = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (rd_req_ack) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("ack_seen", got, 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    chk("en_cycles", en_cnt, m_en);
    chk("frame_drained", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Per-cycle checker: ack timing, hold-while-stalled, enable count, and stream contents.
  logic       p_stall, p_lastv, p_last_hs;
  logic [7:0] p_data;
  logic [8:0] e;
  initial begin
    p_stall = 0; p_lastv = 0; p_last_hs = 0; p_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_stall = 0; p_last_hs = 0;
      end else begin
        chk("ack_timing", rd_req_ack, p_last_hs);
        if (p_stall) begin
          chk("hold_valid", tx_valid, 1);
          chk("hold_data", tx_data, p_data);
          chk("hold_last", tx_last, p_lastv);
        end
        if (grp_rd_en) begin
          en_cnt++;
          chk("grp_sel", grp_sel, cur_id);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e[7:0]);
            chk("tx_last", tx_last, e[8]);
          end
        end
        p_stall   = tx_valid && !tx_ready;
        p_data    = tx_data;
        p_lastv   = tx_last;
        p_last_hs = tx_valid && tx_ready && tx_last;
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = tgl ? ~tx_ready : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_en"},    grp_rd_en, 0);
    chk({nm, "_valid"}, tx_valid, 0);
    chk({nm, "_last"},  tx_last, 0);
    chk({nm, "_data"},  tx_data, 0);
    chk({nm, "_ack"},   rd_req_ack, 0);
    chk({nm, "_sel"},   grp_sel, 0);
  endtask

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; rd_slave_id = 4'd0; tgl = 1'b0;
    grp_rd_valid = 1'b0; grp_rd_data = 8'h00; grp_rd_last = 1'b0;
    cur_id = 4'd0; en_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three beats captured: everything clears at once, no ack.
    cur_id = 4'd3;
    rd_req = 1'b1; rd_slave_id = 4'd3;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      grp_rd_valid = 1'b1; grp_rd_data = 8'(8'hE0 + i); grp_rd_last = 1'b0;
      @(posedge clk); #1;
    end
    grp_rd_valid = 1'b0;
    chk("mid_en_before", grp_rd_en, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    rd_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    clear_beats();
    add_beat(1, 8'h11, 0); add_beat(1, 8'h22, 0); add_beat(1, 8'h33, 1);
    run_frame(4'd2);
    chk("pin_basic_size", mfr.size(), 5);
    chk("pin_basic_hdr", mfr[0], 9'h082);
    chk("pin_basic_len", mfr[1], 9'h003);
    chk("pin_basic_tail", mfr[4], 9'h133);
    chk("pin_basic_en", m_en, 3);

    clear_beats();
    for (int i = 1; i <= 6; i++) add_beat(1, 8'(i), 0);
    run_frame(4'd1);
    chk("pin_ovf_size", mfr.size(), 6);
    chk("pin_ovf_hdr", mfr[0], 9'h0A1);
    chk("pin_ovf_len", mfr[1], 9'h004);
    chk("pin_ovf_tail", mfr[5], 9'h104);
    chk("pin_ovf_en", m_en, 4);

    clear_beats();
    run_frame(4'd0);
    chk("pin_tmo_size", mfr.size(), 2);
    chk("pin_tmo_hdr", mfr[0], 9'h0C0);
    chk("pin_tmo_len", mfr[1], 9'h100);
    chk("pin_tmo_en", m_en, 5);

    tgl = 1'b1;
    clear_beats();
    add_beat(1, 8'hA5, 0); add_beat(1, 8'h5A, 1);
    run_frame(4'd3);
    chk("pin_bp_hdr", mfr[0], 9'h083);
    chk("pin_bp_len", mfr[1], 9'h002);
    chk("pin_bp_tail", mfr[3], 9'h15A);
    tgl = 1'b0;

    clear_beats();
    add_beat(1, 8'h10, 0); add_beat(0, 8'h00, 0); add_beat(0, 8'h00, 0); add_beat(1, 8'h20, 1);
    run_frame(4'd1);
    chk("pin_gap_hdr", mfr[0], 9'h081);
    chk("pin_gap_len", mfr[1], 9'h002);

    clear_beats();
    add_beat(1, 8'hC1, 0); add_beat(1, 8'hC2, 0); add_beat(1, 8'hC3, 0); add_beat(1, 8'hC4, 1);
    run_frame(4'd2);
    chk("pin_full_hdr", mfr[0], 9'h082);
    chk("pin_full_len", mfr[1], 9'h004);

    clear_beats();
    add_beat(1, 8'h77, 0);
    run_frame(4'd2);
    chk("pin_ptmo_hdr", mfr[0], 9'h0C2);
    chk("pin_ptmo_tail", mfr[2], 9'h177);
    chk("pin_ptmo_en", m_en, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
